// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative multiply/divide unit for the HI/LO path of the multi-cycle core.
//   Executes MULT, MULTU, DIV and DIVU one bit per cycle. Every operation,
//   including divide by zero, takes WIDTH+1 cycles from the start edge to ready.
//
// Ports
//   clk      rising-edge clock
//   reset_n  synchronous, active-low reset
//   start    request, accepted only while idle (busy=0)
//   op       00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with start)
//   A        multiplicand / dividend (sampled with start)
//   B        multiplier / divisor (sampled with start)
//   hi       product upper half, or remainder
//   lo       product lower half, or quotient
//   busy     operation in progress
//   ready    hi/lo hold the result of the most recent accepted operation
//
// States
//   S_IDLE | waiting for start; hi/lo hold the last result
//   S_CALC | WIDTH shift-add or restoring-divide iterations
//   S_FIX  | sign correction, divide-by-zero override, hi/lo write
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             ready
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_is_div;
  logic               r_neg_q;    // product / quotient must be negated
  logic               r_neg_r;    // remainder must be negated
  logic               r_bzero;
  logic [WIDTH-1:0]   r_a_raw;
  // Multiply: |A| added into the upper half. Divide: |B| is the divisor.
  logic [WIDTH-1:0]   r_opnd;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide: lower half shifts the dividend out and the quotient in.
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH:0]     r_rem;

  logic               w_signed;
  logic               w_op_div;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH+1:0]   w_shift;
  logic [WIDTH+1:0]   w_diff;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;

  assign w_signed = ~op[0];
  assign w_op_div = op[1];

  // Magnitudes stay unsigned WIDTH bits so that -2^(WIDTH-1) maps to 2^(WIDTH-1).
  assign w_a_mag = (w_signed && A[WIDTH-1]) ? -A : A;
  assign w_b_mag = (w_signed && B[WIDTH-1]) ? -B : B;

  // Multiply iteration: conditional add of the multiplicand, carry kept in w_sum.
  assign w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                 (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});

  // Divide iteration: shift in the next dividend bit, trial-subtract the divisor.
  // The extra top bit of w_diff is the borrow that decides the quotient bit.
  assign w_shift = {r_rem, r_acc[WIDTH-1]};
  assign w_diff  = w_shift - {2'b00, r_opnd};
  assign w_ge    = ~w_diff[WIDTH+1];

  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];

  always_comb begin
    w_fix_hi = '0;
    w_fix_lo = '0;
    if (!r_is_div) begin
      {w_fix_hi, w_fix_lo} = w_prod;
    end else if (r_bzero) begin
      // Divide by zero: report the original dividend, no sign fix-up.
      w_fix_hi = r_a_raw;
      w_fix_lo = '1;
    end else begin
      w_fix_hi = w_rem;
      w_fix_lo = w_quo;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_bzero  <= 1'b0;
      r_a_raw  <= '0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      ready    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_is_div <= w_op_div;
            r_neg_q  <= w_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
            r_neg_r  <= w_signed & A[WIDTH-1];
            r_bzero  <= (B == '0);
            r_a_raw  <= A;
            r_opnd   <= w_op_div ? w_b_mag : w_a_mag;
            r_acc    <= {{WIDTH{1'b0}}, (w_op_div ? w_a_mag : w_b_mag)};
            r_rem    <= '0;
            r_cnt    <= '0;
            busy     <= 1'b1;
            ready    <= 1'b0;
            r_state  <= S_CALC;
          end
        end

        S_CALC: begin
          if (r_is_div) begin
            r_rem <= w_ge ? w_diff[WIDTH:0] : w_shift[WIDTH:0];
            r_acc <= {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-2:0], w_ge};
          end else begin
            r_acc <= {w_sum, r_acc[WIDTH-1:1]};
          end
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_state <= S_FIX;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_FIX: begin
          hi      <= w_fix_hi;
          lo      <= w_fix_lo;
          busy    <= 1'b0;
          ready   <= 1'b1;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
